int_mul_add: RTL

- Sequential shift-add unsigned multiplier with addend; computes product = multiplicand * multiplier + addend.
- This is the inverse of the team's restoring integer divider. Feeding it a divider's quotient, divisor and remainder must reproduce the original dividend.
- Used as a divide-result checker and as a general multi-cycle multiply unit.
- Uses the same start/ready handshake style as the divider.

---
 rtl/int_mul_add.sv | 84 ++++++++
 1 files changed

// File: rtl/int_mul_add.sv
// Multi-cycle shift-add unsigned multiply with addend: product = multiplicand * multiplier + addend.
// Fixed WIDTH-cycle latency; start is ignored while busy (ready=0), result and done are registered.
module int_mul_add #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   addend,
   output logic [2*WIDTH-1:0] product,
   output logic               ovf,
   output logic               ready,
   output logic               done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mreg;
   logic [WIDTH-1:0]   breg;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] sum;
   logic               last;
   logic               accept;

   // acc cannot exceed 2^(2W) - 2^W, so the sum needs no carry bit
   assign sum    = breg[0] ? acc + mreg : acc;
   assign last   = (cnt == CW'(1));
   assign accept = (state == IDLE) && start;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         mreg    <= '0;
         breg    <= '0;
         cnt     <= '0;
         product <= '0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            acc  <= {{WIDTH{1'b0}}, addend};
            mreg <= {{WIDTH{1'b0}}, multiplicand};
            breg <= multiplier;
            cnt  <= CW'(WIDTH);
         end else if (state == RUN) begin
            acc  <= sum;
            mreg <= {mreg[2*WIDTH-2:0], 1'b0};
            breg <= {1'b0, breg[WIDTH-1:1]};
            cnt  <= cnt - CW'(1);
            if (last) begin
               product <= sum;
               ovf     <= |sum[2*WIDTH-1:WIDTH];
               done    <= 1'b1;
            end
         end
      end
   end

endmodule
